// File: rtl/alu_4_bit_bist.sv
// alu_4_bit_bist: on-chip stimulus/response engine for the 4-bit ALU.
// One Start pulse sweeps every A/B pair for ADD, then every pair for SUB.
// Each ALU response is checked against golden values computed here.
// The engine counts mismatching vectors and keeps the first failing vector
// together with the response that was observed for it.
module alu_4_bit_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [9:0] Fail_Count,
    output logic       First_Fail_Valid,
    output logic [8:0] First_Fail_Vec,
    output logic [6:0] First_Fail_Obs,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       AINV,
    output logic       BNEG,
    output logic [1:0] Opr,
    input  logic [3:0] RESULT,
    input  logic       OVERFLOW,
    input  logic       ZERO,
    input  logic       COUT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The last settle count before the response is sampled (SETTLE_CYCLES is 1..15).
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [8:0] LAST_VEC    = 9'h1FF;

    state_t     state_q, state_d;
    logic [8:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic [9:0] failCount_q, failCount_d;
    logic       firstValid_q, firstValid_d;
    logic [8:0] firstVec_q, firstVec_d;
    logic [6:0] firstObs_q, firstObs_d;

    logic       startSweep;
    logic [4:0] sumAdd;
    logic [4:0] sumSub;
    logic [6:0] goldenObs;
    logic [6:0] aluObs;
    logic       mismatch;

    // A Start is honoured only while no sweep is running.
    assign startSweep = Start && ((state_q == IDLE) || (state_q == DONE));

    // The ALU is driven straight from the registered vector counter.
    assign BNEG = vec_q[8];
    assign A    = vec_q[7:4];
    assign B    = vec_q[3:0];
    assign AINV = 1'b0;
    assign Opr  = 2'b10;

    assign Fail_Count       = failCount_q;
    assign First_Fail_Valid = firstValid_q;
    assign First_Fail_Vec   = firstVec_q;
    assign First_Fail_Obs   = firstObs_q;

    // Golden response for the vector being presented, packed as {COUT, OVERFLOW, ZERO, RESULT}.
    always_comb begin
        sumAdd    = {1'b0, vec_q[7:4]} + {1'b0, vec_q[3:0]};
        sumSub    = {1'b0, vec_q[7:4]} + {1'b0, ~vec_q[3:0]} + 5'd1;
        goldenObs = 7'd0;
        if (!vec_q[8]) begin
            goldenObs[6]   = sumAdd[4];
            goldenObs[5]   = (vec_q[7] == vec_q[3]) && (sumAdd[3] != vec_q[7]);
            goldenObs[4]   = (sumAdd[3:0] == 4'd0);
            goldenObs[3:0] = sumAdd[3:0];
        end else begin
            goldenObs[6]   = sumSub[4];
            goldenObs[5]   = (vec_q[7] != vec_q[3]) && (sumSub[3] != vec_q[7]);
            goldenObs[4]   = (sumSub[3:0] == 4'd0);
            goldenObs[3:0] = sumSub[3:0];
        end
    end

    // Any differing response bit makes the whole vector a single failure.
    assign aluObs   = {COUT, OVERFLOW, ZERO, RESULT};
    assign mismatch = (aluObs != goldenObs);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: settle, check, then either the next vector or the end of the sweep.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the current state; Pass only means something once done.
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        Pass = 1'b0;
        case (state_q)
            SETTLE, CHECK: Busy = 1'b1;
            DONE: begin
                Done = 1'b1;
                Pass = (failCount_q == 10'd0);
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    // Datapath next values: vector/settle stepping and first-failure capture.
    always_comb begin
        vec_d        = vec_q;
        settle_d     = settle_q;
        failCount_d  = failCount_q;
        firstValid_d = firstValid_q;
        firstVec_d   = firstVec_q;
        firstObs_d   = firstObs_q;
        if (startSweep) begin
            vec_d        = 9'd0;
            settle_d     = 4'd0;
            failCount_d  = 10'd0;
            firstValid_d = 1'b0;
            firstVec_d   = 9'd0;
            firstObs_d   = 7'd0;
        end else if (state_q == SETTLE) begin
            settle_d = settle_q + 4'd1;
        end else if (state_q == CHECK) begin
            if (mismatch) begin
                failCount_d = failCount_q + 10'd1;
                if (!firstValid_q) begin
                    firstValid_d = 1'b1;
                    firstVec_d   = vec_q;
                    firstObs_d   = aluObs;
                end
            end
            if (vec_q != LAST_VEC) begin
                vec_d    = vec_q + 9'd1;
                settle_d = 4'd0;
            end
        end
    end

    // Datapath registers; results stay frozen in DONE because nothing steps them there.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vec_q        <= 9'd0;
            settle_q     <= 4'd0;
            failCount_q  <= 10'd0;
            firstValid_q <= 1'b0;
            firstVec_q   <= 9'd0;
            firstObs_q   <= 7'd0;
        end else begin
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            failCount_q  <= failCount_d;
            firstValid_q <= firstValid_d;
            firstVec_q   <= firstVec_d;
            firstObs_q   <= firstObs_d;
        end
    end

endmodule

// File: tb/tb_alu_4_bit_bist.sv
// tb_alu_4_bit_bist: drives alu_4_bit_bist against a behavioural 4-bit ALU
// that can be switched between a correct model and two faulty ones.
module tb_alu_4_bit_bist;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Busy;
    logic       Done;
    logic       Pass;
    logic [9:0] Fail_Count;
    logic       First_Fail_Valid;
    logic [8:0] First_Fail_Vec;
    logic [6:0] First_Fail_Obs;
    logic [3:0] A;
    logic [3:0] B;
    logic       AINV;
    logic       BNEG;
    logic [1:0] Opr;
    logic [3:0] RESULT;
    logic       OVERFLOW;
    logic       ZERO;
    logic       COUT;

    // 0 = correct ALU, 1 = COUT stuck at 0, 2 = OVERFLOW inverted
    int aluMode;

    int assertCount;
    int failCount;

    typedef struct {
        int         mode;
        int         expCount;
        logic       expPass;
        logic       expValid;
        logic [8:0] expVec;
        logic [6:0] expObs;
    } sweepCase_t;

    typedef struct {
        int         n;
        logic [3:0] expA;
        logic [3:0] expB;
        logic       expBneg;
    } spotCase_t;

    sweepCase_t sweepTable[3];
    spotCase_t  spotTable[6];

    alu_4_bit_bist #(.SETTLE_CYCLES(2)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Start            (Start),
        .Busy             (Busy),
        .Done             (Done),
        .Pass             (Pass),
        .Fail_Count       (Fail_Count),
        .First_Fail_Valid (First_Fail_Valid),
        .First_Fail_Vec   (First_Fail_Vec),
        .First_Fail_Obs   (First_Fail_Obs),
        .A                (A),
        .B                (B),
        .AINV             (AINV),
        .BNEG             (BNEG),
        .Opr              (Opr),
        .RESULT           (RESULT),
        .OVERFLOW         (OVERFLOW),
        .ZERO             (ZERO),
        .COUT             (COUT)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural ALU built on integer arithmetic, returning {COUT, OVERFLOW, ZERO, RESULT}.
    function automatic logic [6:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                            input logic bneg, input int mode);
        int         ua;
        int         ub;
        int         sa;
        int         sb;
        int         u;
        int         s;
        logic       cout;
        logic       ovf;
        logic [3:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        if (!bneg) begin
            u    = ua + ub;
            s    = sa + sb;
            cout = (u > 15);
        end else begin
            u    = ua - ub;
            s    = sa - sb;
            cout = (ua >= ub);
        end
        res = 4'(u & 15);
        ovf = (s > 7) || (s < -8);
        if (mode == 1) cout = 1'b0;
        if (mode == 2) ovf = ~ovf;
        return {cout, ovf, (res == 4'd0), res};
    endfunction

    assign {COUT, OVERFLOW, ZERO, RESULT} = aluModel(A, B, BNEG, aluMode);

    // One comparison: counts it, reports it on a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Hold Start high across exactly one rising edge.
    task automatic applyStimulus();
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic doReset();
        @(negedge Clk);
        Reset = 1'b1;
        waitEdges(2);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        aluMode     = 0;
        Reset       = 1'b1;
        Start       = 1'b0;

        sweepTable[0] = '{mode: 0, expCount: 0,   expPass: 1'b1, expValid: 1'b0, expVec: 9'h000, expObs: 7'b0000000};
        sweepTable[1] = '{mode: 1, expCount: 256, expPass: 1'b0, expValid: 1'b1, expVec: 9'h01F, expObs: 7'b0010000};
        sweepTable[2] = '{mode: 2, expCount: 512, expPass: 1'b0, expValid: 1'b1, expVec: 9'h000, expObs: 7'b0110000};

        spotTable[0] = '{n: 0,     expA: 4'h0, expB: 4'h0, expBneg: 1'b0};
        spotTable[1] = '{n: 1,     expA: 4'h0, expB: 4'h1, expBneg: 1'b0};
        spotTable[2] = '{n: 2,     expA: 4'h0, expB: 4'h2, expBneg: 1'b0};
        spotTable[3] = '{n: 16,    expA: 4'h1, expB: 4'h0, expBneg: 1'b0};
        spotTable[4] = '{n: 'h145, expA: 4'h4, expB: 4'h5, expBneg: 1'b1};
        spotTable[5] = '{n: 'h1FF, expA: 4'hF, expB: 4'hF, expBneg: 1'b1};

        // Reset state
        waitEdges(2);
        checkOutput("reset Busy", 32'(Busy), 32'd0);
        checkOutput("reset Done", 32'(Done), 32'd0);
        checkOutput("reset Pass", 32'(Pass), 32'd0);
        checkOutput("reset Fail_Count", 32'(Fail_Count), 32'd0);
        checkOutput("reset First_Fail_Valid", 32'(First_Fail_Valid), 32'd0);
        checkOutput("reset First_Fail_Vec", 32'(First_Fail_Vec), 32'd0);
        checkOutput("reset First_Fail_Obs", 32'(First_Fail_Obs), 32'd0);
        checkOutput("reset A", 32'(A), 32'd0);
        checkOutput("reset B", 32'(B), 32'd0);
        checkOutput("reset BNEG", 32'(BNEG), 32'd0);
        checkOutput("reset AINV", 32'(AINV), 32'd0);
        checkOutput("reset Opr", 32'(Opr), 32'd2);
        @(negedge Clk);
        Reset = 1'b0;

        // Vector timing: vector n is on the ALU from edge k+3n and held through k+3n+2
        $display("[TB] vector timing sweep, correct ALU");
        aluMode = 0;
        applyStimulus();
        checkOutput("Busy after Start", 32'(Busy), 32'd1);
        begin
            int cur;
            cur = 0;
            for (int i = 0; i < 6; i++) begin
                waitEdges(3 * spotTable[i].n - cur);
                checkOutput($sformatf("vec%0h A", spotTable[i].n), 32'(A), 32'(spotTable[i].expA));
                checkOutput($sformatf("vec%0h B", spotTable[i].n), 32'(B), 32'(spotTable[i].expB));
                checkOutput($sformatf("vec%0h BNEG", spotTable[i].n), 32'(BNEG), 32'(spotTable[i].expBneg));
                waitEdges(2);
                checkOutput($sformatf("vec%0h held A", spotTable[i].n), 32'(A), 32'(spotTable[i].expA));
                checkOutput($sformatf("vec%0h held B", spotTable[i].n), 32'(B), 32'(spotTable[i].expB));
                cur = 3 * spotTable[i].n + 2;
                if (spotTable[i].n == 'h145) begin
                    waitEdges(1);
                    cur++;
                    checkOutput("SUB 4-5 no fail", 32'(Fail_Count), 32'd0);
                    checkOutput("SUB 4-5 still busy", 32'(Busy), 32'd1);
                end
            end
            checkOutput("Done before 1536", 32'(Done), 32'd0);
            checkOutput("Pass before Done", 32'(Pass), 32'd0);
            waitEdges(1536 - cur);
            checkOutput("Done at 1536", 32'(Done), 32'd1);
            checkOutput("Busy at 1536", 32'(Busy), 32'd0);
            checkOutput("DONE holds A", 32'(A), 32'hF);
            checkOutput("DONE holds B", 32'(B), 32'hF);
            checkOutput("DONE holds BNEG", 32'(BNEG), 32'd1);
        end

        // Full sweeps against each ALU model
        for (int i = 0; i < 3; i++) begin
            $display("[TB] full sweep, ALU mode %0d", sweepTable[i].mode);
            doReset();
            aluMode = sweepTable[i].mode;
            applyStimulus();
            waitEdges(1535);
            checkOutput($sformatf("mode%0d Done@1535", i), 32'(Done), 32'd0);
            checkOutput($sformatf("mode%0d Busy@1535", i), 32'(Busy), 32'd1);
            waitEdges(1);
            checkOutput($sformatf("mode%0d Done", i), 32'(Done), 32'd1);
            checkOutput($sformatf("mode%0d Busy", i), 32'(Busy), 32'd0);
            checkOutput($sformatf("mode%0d Pass", i), 32'(Pass), 32'(sweepTable[i].expPass));
            checkOutput($sformatf("mode%0d Fail_Count", i), 32'(Fail_Count), 32'(sweepTable[i].expCount));
            checkOutput($sformatf("mode%0d First_Fail_Valid", i), 32'(First_Fail_Valid), 32'(sweepTable[i].expValid));
            checkOutput($sformatf("mode%0d First_Fail_Vec", i), 32'(First_Fail_Vec), 32'(sweepTable[i].expVec));
            checkOutput($sformatf("mode%0d First_Fail_Obs", i), 32'(First_Fail_Obs), 32'(sweepTable[i].expObs));
        end

        // Reset mid-sweep with every vector failing
        $display("[TB] reset mid-sweep");
        doReset();
        aluMode = 2;
        applyStimulus();
        waitEdges(99);
        checkOutput("mid-sweep Fail_Count", 32'(Fail_Count), 32'd33);
        @(negedge Clk);
        Reset = 1'b1;
        waitEdges(1);
        checkOutput("mid reset Busy", 32'(Busy), 32'd0);
        checkOutput("mid reset Done", 32'(Done), 32'd0);
        checkOutput("mid reset Fail_Count", 32'(Fail_Count), 32'd0);
        checkOutput("mid reset First_Fail_Valid", 32'(First_Fail_Valid), 32'd0);
        checkOutput("mid reset A", 32'(A), 32'd0);
        checkOutput("mid reset B", 32'(B), 32'd0);
        checkOutput("mid reset BNEG", 32'(BNEG), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Start while busy is ignored; Start in DONE restarts
        $display("[TB] Start during sweep and restart from DONE");
        doReset();
        aluMode = 1;
        applyStimulus();
        waitEdges(49);
        applyStimulus();
        checkOutput("no restart @50 A", 32'(A), 32'h1);
        checkOutput("no restart @50 B", 32'(B), 32'h0);
        waitEdges(149);
        applyStimulus();
        checkOutput("no restart @200 A", 32'(A), 32'h4);
        checkOutput("no restart @200 B", 32'(B), 32'h2);
        waitEdges(1335);
        checkOutput("busy-start Done@1535", 32'(Done), 32'd0);
        waitEdges(1);
        checkOutput("busy-start Done@1536", 32'(Done), 32'd1);
        checkOutput("busy-start Fail_Count", 32'(Fail_Count), 32'd256);
        applyStimulus();
        checkOutput("restart Done", 32'(Done), 32'd0);
        checkOutput("restart Busy", 32'(Busy), 32'd1);
        checkOutput("restart Fail_Count", 32'(Fail_Count), 32'd0);
        checkOutput("restart First_Fail_Valid", 32'(First_Fail_Valid), 32'd0);
        checkOutput("restart A", 32'(A), 32'd0);
        checkOutput("restart BNEG", 32'(BNEG), 32'd0);
        waitEdges(1535);
        checkOutput("second Done@1535", 32'(Done), 32'd0);
        waitEdges(1);
        checkOutput("second Done@1536", 32'(Done), 32'd1);
        checkOutput("second Fail_Count", 32'(Fail_Count), 32'd256);
        checkOutput("second First_Fail_Vec", 32'(First_Fail_Vec), 32'h01F);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_4_bit_bist.md
# alu_4_bit_bist

Self-checking hardware stimulus/response engine for the 4-bit ALU: it drives the ALU's operand and control inputs and checks the ALU's RESULT, OVERFLOW, ZERO and COUT outputs. On a Start pulse it sweeps all 256 A/B pairs for ADD, then all 256 pairs for SUB. It compares every response against internally computed golden values, counts mismatches and captures the first failing vector. It sits beside `alu_4_bit` on the lab board and replaces bench-driven checking with an on-chip pass/fail verdict.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: cycles the ALU inputs are held before the response is sampled; legal range 1..15.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begins a sweep when sampled high in IDLE or DONE.
- Busy  out  1  high in SETTLE or CHECK.
- Done  out  1  high in DONE.
- Pass  out  1  high in DONE when Fail_Count == 0.
- Fail_Count  out  10  mismatch count for the current or last sweep (0..512).
- First_Fail_Valid  out  1  a mismatch has been captured.
- First_Fail_Vec  out  9  {BNEG, A, B} of the first mismatch.
- First_Fail_Obs  out  7  {COUT, OVERFLOW, ZERO, RESULT} observed at the first mismatch.
- A  out  4  ALU operand A.
- B  out  4  ALU operand B.
- AINV  out  1  ALU control; constant 0.
- BNEG  out  1  ALU control; 0 for ADD, 1 for SUB.
- Opr  out  2  ALU control; constant 2'b10 (arithmetic).
- RESULT  in  4  ALU result.
- OVERFLOW  in  1  ALU signed-overflow flag.
- ZERO  in  1  ALU zero flag.
- COUT  in  1  ALU carry-out flag.

## Operation
- The 9-bit vector counter V supplies the ALU drive: BNEG = V[8], A = V[7:4], B = V[3:0]. These outputs are driven directly from the registered V.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE: Start → V=0, settle counter=0, Fail_Count=0, First_Fail_Valid=0, First_Fail_Vec=0, First_Fail_Obs=0, next state SETTLE.
  - SETTLE: the settle counter increments each cycle. When it reaches SETTLE_CYCLES-1 the FSM moves to CHECK.
  - CHECK: the ALU response is compared against the golden values.
    - On a mismatch, Fail_Count increments.
    - If First_Fail_Valid is 0, First_Fail_Vec and First_Fail_Obs are captured and First_Fail_Valid is set.
    - If V == 511 the FSM moves to DONE. Otherwise V increments, the settle counter clears and the FSM moves to SETTLE.
  - DONE: holds all results. Start restarts the sweep exactly as from IDLE.
- Start is ignored in SETTLE and CHECK.
- Golden ADD: s = {0,A} + {0,B}.
  - RESULT = s[3:0], COUT = s[4], ZERO = (s[3:0] == 0).
  - OVERFLOW = (A[3] == B[3]) && (s[3] != A[3]).
- Golden SUB: s = {0,A} + {0,~B} + 1.
  - RESULT = s[3:0], ZERO = (s[3:0] == 0).
  - COUT = s[4], which is 1 iff A ≥ B unsigned.
  - OVERFLOW = (A[3] != B[3]) && (s[3] != A[3]).
- A vector fails if any of its 7 response bits differs from golden. Each vector counts at most once.
- Fail_Count cannot exceed 512, so no saturation logic is needed.

## Timing
- Reset, including mid-sweep, takes effect at the next edge:
  - state IDLE, V=0;
  - A=0, B=0, BNEG=0, AINV=0, Opr=2'b10;
  - Busy=0, Done=0, Pass=0;
  - Fail_Count=0, First_Fail_Valid=0, First_Fail_Vec=0, First_Fail_Obs=0.
- Reset has priority over Start.
- Start sampled at edge k: Busy=1 after edge k. Vector n is presented from edge k + n·(SETTLE_CYCLES+1).
- Vector n is compared at edge k + (n+1)·(SETTLE_CYCLES+1), sampling ALU outputs that were held stable for SETTLE_CYCLES full cycles.
- Done=1 after edge k + 512·(SETTLE_CYCLES+1); with the default this is k+1536. Busy drops in the same cycle.
- Pass is valid only while Done=1 and is 0 otherwise.
- Fail_Count and First_Fail_* update at the CHECK edge and are observable during the sweep.
- In DONE, A/B/BNEG hold the last vector, {1,1111,1111}, until restart or Reset.

## Test plan
- Correct behavioural ALU, SETTLE_CYCLES=2, Start pulse at edge k:
  - Done rises after edge k+1536, Pass=1, Fail_Count=0, First_Fail_Valid=0.
  - A/B change every 3 cycles.
- Spot check of SUB A=4, B=5: V=0x145 is presented at edge k+325·3. Golden RESULT=4'b1111, COUT=0, OVERFLOW=0, ZERO=0; correct ALU gives no fail.
- ALU model with COUT stuck-at-0:
  - Fail_Count=256 (120 ADD carries + 136 SUB A≥B), Pass=0.
  - First_Fail_Vec=9'h01F (ADD 1+15).
  - First_Fail_Obs={0,0,1,0000}.
- ALU model with inverted OVERFLOW:
  - Fail_Count=512.
  - First_Fail_Vec=0, First_Fail_Obs={0,1,1,0000}.
- Reset asserted at edge k+100 mid-sweep: after that edge Busy=0, Fail_Count=0, A=B=0, BNEG=0, Done=0.
- Start toggled during Busy causes no restart and no timing shift. Start in DONE restarts: Done=0, Fail_Count=0 after that edge, and a second Done follows 1536 cycles later.
